// File: rtl/pg_retention_block_model.sv
// ---------------------------------------------------------------------------
// pg_retention_block_model
//
// Behavioural model of a power-gated block with state retention. NUM_REGS
// live registers are lost on power-off; an always-on shadow bank preserves
// them across a save / power-off / restore sequence. Save and restore use
// 4-phase level handshakes with fixed latencies counted in clock edges.
// Sequencing mistakes made by the controller set a sticky error flag.
//
// Ports
//   clk, rst_n                 clock, async active-low reset (always-on)
//   pwr_on                     power switch status, 0 = block unpowered
//   iso_en                     isolation: forces rd_data to 0
//   save_req / save_ack        save handshake (ack held while req high)
//   restore_req / restore_ack  restore handshake (ack held while req high)
//   wr_en, wr_addr, wr_data    live register write port (ACTIVE only)
//   rd_addr, rd_data           combinational read of the live registers
//   err, err_clr               sticky sequencing error and its clear
//   state_o                    current state encoding
// ---------------------------------------------------------------------------
module pg_retention_block_model #(
  parameter int                DATA_W      = 8,
  parameter int                NUM_REGS    = 4,
  parameter int                SAVE_LAT    = 2,
  parameter int                RESTORE_LAT = 3,
  parameter logic [DATA_W-1:0] CORRUPT_VAL = DATA_W'(8'hA5),
  localparam int               AW          = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_on,
  input  logic              iso_en,
  input  logic              save_req,
  output logic              save_ack,
  input  logic              restore_req,
  output logic              restore_ack,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  input  logic              err_clr,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_SAVING    = 3'd1,
    ST_SAVED     = 3'd2,
    ST_OFF       = 3'd3,
    ST_RESTORING = 3'd4,
    ST_RESTORED  = 3'd5
  } state_t;

  localparam int MAX_LAT = (SAVE_LAT > RESTORE_LAT) ? SAVE_LAT : RESTORE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] SAVE_LAST    = CNT_W'(SAVE_LAT - 1);
  localparam logic [CNT_W-1:0] RESTORE_LAST = CNT_W'(RESTORE_LAT - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] live   [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic              shadow_valid;

  // Control strobes decoded from the current state and inputs.
  logic live_we, snap, cnt_clr, cnt_inc, corrupt, restore_load;
  logic sv_set, sv_clr, err_set;
  logic wr_addr_ok, rd_addr_ok;

  // Address range checks only matter when NUM_REGS is not a power of two.
  if ((1 << AW) == NUM_REGS) begin : g_full_range
    assign wr_addr_ok = 1'b1;
    assign rd_addr_ok = 1'b1;
  end else begin : g_part_range
    assign wr_addr_ok = (int'(wr_addr) < NUM_REGS);
    assign rd_addr_ok = (int'(rd_addr) < NUM_REGS);
  end

  // State register.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACTIVE;
    else        state <= next_state;
  end

  // Next-state logic. Loss of power takes priority over every handshake.
  always_comb begin
    // NOTE: default assignment first, so no path leaves next_state unassigned
    // and no latch is inferred.
    next_state = state;
    unique case (state)
      ST_ACTIVE:    if (!pwr_on)                   next_state = ST_OFF;
                    else if (save_req)             next_state = ST_SAVING;
      ST_SAVING:    if (!pwr_on)                   next_state = ST_OFF;
                    else if (!save_req)            next_state = ST_ACTIVE;
                    else if (cnt == SAVE_LAST)     next_state = ST_SAVED;
      ST_SAVED:     if (!pwr_on)                   next_state = ST_OFF;
                    else if (!save_req)            next_state = ST_ACTIVE;
      ST_OFF:       if (pwr_on && restore_req)     next_state = ST_RESTORING;
      ST_RESTORING: if (!pwr_on)                   next_state = ST_OFF;
                    else if (cnt == RESTORE_LAST)  next_state = ST_RESTORED;
      ST_RESTORED:  if (!pwr_on)                   next_state = ST_OFF;
                    else if (!restore_req)         next_state = ST_ACTIVE;
      default:                                     next_state = ST_ACTIVE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    live_we      = (state == ST_ACTIVE) && pwr_on && wr_en && wr_addr_ok;
    snap         = (state == ST_ACTIVE) && pwr_on && save_req;
    cnt_clr      = snap || ((state == ST_OFF) && (next_state == ST_RESTORING));
    cnt_inc      = (state == ST_SAVING) || (state == ST_RESTORING);
    corrupt      = (state != ST_OFF) && !pwr_on;
    restore_load = (state == ST_RESTORING) && (next_state == ST_RESTORED);
    sv_set       = (state == ST_SAVING) && (next_state == ST_SAVED);
    sv_clr       = ((state == ST_SAVING)   && (next_state == ST_ACTIVE)) ||
                   ((state == ST_RESTORED) && (next_state == ST_ACTIVE)) ||
                   (!pwr_on && ((state == ST_ACTIVE) || (state == ST_SAVING)));
    // Power loss is only legal from SAVED; any other powered state loses data.
    err_set      = (corrupt && (state != ST_SAVED)) ||
                   (restore_load && !shadow_valid) ||
                   (wr_en && !pwr_on && (state != ST_ACTIVE));
    rd_data      = (iso_en || !rd_addr_ok) ? '0 : live[rd_addr];
    state_o      = state;
  end

  // Datapath: live/shadow banks, latency counter, handshake acks, error flag.
  // NOTE: the register banks are reset explicitly: their post-reset contents
  // are observable through rd_data and the restore path, so they are state,
  // not scratch memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      shadow_valid <= 1'b0;
      cnt          <= '0;
      save_ack     <= 1'b0;
      restore_ack  <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (corrupt) begin
        for (int i = 0; i < NUM_REGS; i++) live[i] <= CORRUPT_VAL;
      end else if (restore_load) begin
        for (int i = 0; i < NUM_REGS; i++) live[i] <= shadow_valid ? shadow[i] : '0;
      end else if (live_we) begin
        live[wr_addr] <= wr_data;
      end

      if (snap) begin
        for (int i = 0; i < NUM_REGS; i++) shadow[i] <= live[i];
      end

      if (sv_set)      shadow_valid <= 1'b1;
      else if (sv_clr) shadow_valid <= 1'b0;

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      // Acks are registered: they rise on the edge entering the held state
      // and fall on the edge leaving it.
      save_ack    <= (next_state == ST_SAVED);
      restore_ack <= (next_state == ST_RESTORED);

      // Setting the error wins over a simultaneous clear.
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pg_retention_block_model.sv
// ---------------------------------------------------------------------------
// tb_pg_retention_block_model
//
// Directed bench for pg_retention_block_model. Instance u_dut uses the
// default parameters and is driven from a table of per-cycle vectors; u_dut2
// uses DATA_W=16, NUM_REGS=8, SAVE_LAT=1, RESTORE_LAT=5 and runs a full
// save / power-off / restore cycle with measured latencies.
// ---------------------------------------------------------------------------
module tb_pg_retention_block_model;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic       pwr_on, iso_en, save_req, restore_req, wr_en, err_clr;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       save_ack, restore_ack, err;
  logic [2:0] state_o;

  pg_retention_block_model u_dut (
    .clk(clk), .rst_n(rst_n), .pwr_on(pwr_on), .iso_en(iso_en),
    .save_req(save_req), .save_ack(save_ack),
    .restore_req(restore_req), .restore_ack(restore_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .err(err), .err_clr(err_clr), .state_o(state_o)
  );

  // ---------------- wide / fast-save instance ----------------
  logic        pwr_on2, iso_en2, save_req2, restore_req2, wr_en2, err_clr2;
  logic [2:0]  wr_addr2, rd_addr2;
  logic [15:0] wr_data2, rd_data2;
  logic        save_ack2, restore_ack2, err2;
  logic [2:0]  state_o2;

  pg_retention_block_model #(
    .DATA_W(16), .NUM_REGS(8), .SAVE_LAT(1), .RESTORE_LAT(5),
    .CORRUPT_VAL(16'hDEAD)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pwr_on(pwr_on2), .iso_en(iso_en2),
    .save_req(save_req2), .save_ack(save_ack2),
    .restore_req(restore_req2), .restore_ack(restore_ack2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2),
    .err(err2), .err_clr(err_clr2), .state_o(state_o2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       pwr, iso, sreq, rreq, we;
    bit [1:0] wa;
    bit [7:0] wd;
    bit [1:0] ra;
    bit       clr;
    bit [2:0] exp_st;
    bit       exp_sack, exp_rack, exp_err;
    bit [7:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit p, bit iso, bit s, bit r, bit we, bit [1:0] wa, bit [7:0] wd,
                              bit [1:0] ra, bit clr, bit [2:0] st, bit sa, bit rk, bit e,
                              bit [7:0] rd);
    vec_t v;
    v.pwr = p;  v.iso = iso; v.sreq = s; v.rreq = r; v.we = we;
    v.wa = wa;  v.wd = wd;   v.ra = ra;  v.clr = clr;
    v.exp_st = st; v.exp_sack = sa; v.exp_rack = rk; v.exp_err = e; v.exp_rd = rd;
    return v;
  endfunction

  // Drive one vector on the falling edge, let one rising edge pass, then
  // compare the outputs 1 time unit after that edge.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    pwr_on = v.pwr; iso_en = v.iso; save_req = v.sreq; restore_req = v.rreq;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; rd_addr = v.ra; err_clr = v.clr;
    @(posedge clk);
    #1;
    check({tag, " state"},       32'(state_o),     32'(v.exp_st));
    check({tag, " save_ack"},    32'(save_ack),    32'(v.exp_sack));
    check({tag, " restore_ack"}, 32'(restore_ack), 32'(v.exp_rack));
    check({tag, " err"},         32'(err),         32'(v.exp_err));
    check({tag, " rd_data"},     32'(rd_data),     32'(v.exp_rd));
  endtask

  initial begin
    int lat;

    // Columns: pwr iso sreq rreq we wa wd ra clr | state sack rack err rd
    // Fill live = {11,22,33,44}, isolation check in ACTIVE.
    vecs.push_back(mk(1,0,0,0,1,0,8'h11,0,0, 0,0,0,0,8'h11));
    vecs.push_back(mk(1,0,0,0,1,1,8'h22,1,0, 0,0,0,0,8'h22));
    vecs.push_back(mk(1,0,0,0,1,2,8'h33,2,0, 0,0,0,0,8'h33));
    vecs.push_back(mk(1,0,0,0,1,3,8'h44,3,0, 0,0,0,0,8'h44));
    vecs.push_back(mk(1,1,0,0,0,0,8'h00,0,0, 0,0,0,0,8'h00));
    // Save: E0, E0+1 (write dropped, no err while powered), E0+2 ack.
    vecs.push_back(mk(1,0,1,0,0,0,8'h00,1,0, 1,0,0,0,8'h22));
    vecs.push_back(mk(1,0,1,0,1,0,8'h99,0,0, 1,0,0,0,8'h11));
    vecs.push_back(mk(1,0,1,0,0,0,8'h00,0,0, 2,1,0,0,8'h11));
    vecs.push_back(mk(1,0,1,0,0,0,8'h00,3,0, 2,1,0,0,8'h44));
    // Power off from SAVED (legal), isolated read, then corrupt value.
    vecs.push_back(mk(0,1,1,0,0,0,8'h00,2,0, 3,0,0,0,8'h00));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00,2,0, 3,0,0,0,8'hA5));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00,2,0, 3,0,0,0,8'hA5));
    // Restore: R0..R0+3, data back, then drop request.
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 5,0,1,0,8'h11));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,3,0, 5,0,1,0,8'h44));
    vecs.push_back(mk(1,0,0,0,0,0,8'h00,1,0, 0,0,0,0,8'h22));
    // Power loss in ACTIVE: err, corrupt; restore with no valid shadow -> 0.
    vecs.push_back(mk(0,0,0,0,0,0,8'h00,0,0, 3,0,0,1,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,1,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,1,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,1,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,1,0, 5,0,1,1,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,8'h00,1,0, 0,0,0,1,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,8'h00,1,1, 0,0,0,0,8'h00));
    // Aborted save: no ack, shadow invalid, later restore flags err.
    vecs.push_back(mk(1,0,0,0,1,0,8'h5A,0,0, 0,0,0,0,8'h5A));
    vecs.push_back(mk(1,0,1,0,0,0,8'h00,0,0, 1,0,0,0,8'h5A));
    vecs.push_back(mk(1,0,0,0,0,0,8'h00,0,0, 0,0,0,0,8'h5A));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00,0,0, 3,0,0,1,8'hA5));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00,0,1, 3,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 4,0,0,0,8'hA5));
    vecs.push_back(mk(1,0,0,1,0,0,8'h00,0,0, 5,0,1,1,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,8'h00,0,1, 0,0,0,0,8'h00));
    // Both requests high in ACTIVE: save wins, reaches SAVED.
    vecs.push_back(mk(1,0,0,0,1,2,8'h77,2,0, 0,0,0,0,8'h77));
    vecs.push_back(mk(1,0,1,1,0,0,8'h00,2,0, 1,0,0,0,8'h77));
    vecs.push_back(mk(1,0,1,1,0,0,8'h00,2,0, 1,0,0,0,8'h77));
    vecs.push_back(mk(1,0,1,1,0,0,8'h00,2,0, 2,1,0,0,8'h77));

    // Idle inputs and reset.
    rst_n = 1'b0;
    pwr_on = 1'b1; iso_en = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; err_clr = 1'b0;
    pwr_on2 = 1'b1; iso_en2 = 1'b0; save_req2 = 1'b0; restore_req2 = 1'b0;
    wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0; err_clr2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset state", 32'(state_o), 32'd0);
    check("reset save_ack", 32'(save_ack), 32'd0);
    check("reset restore_ack", 32'(restore_ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      check($sformatf("reset live[%0d]", a), 32'(rd_data), 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset while SAVED: everything clears without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst state", 32'(state_o), 32'd0);
    check("async rst save_ack", 32'(save_ack), 32'd0);
    check("async rst live[2]", 32'(rd_data), 32'd0);
    save_req = 1'b0; restore_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Error set and clear on the same edge: set wins; then unpowered write.
    step(mk(0,0,0,0,0,0,8'h00,0,1, 3,0,0,1,8'hA5), "set_vs_clr");
    step(mk(0,0,0,0,0,0,8'h00,0,1, 3,0,0,0,8'hA5), "clr_in_off");
    step(mk(0,0,0,0,1,1,8'h3C,1,0, 3,0,0,1,8'hA5), "wr_unpowered");
    step(mk(1,0,0,0,0,0,8'h00,1,1, 3,0,0,0,8'hA5), "off_idle_clr");

    // ---------------- wide instance: full cycle with latency measurement ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en2 = 1'b1; wr_addr2 = 3'(i); wr_data2 = 16'(16'h1000 + i * 16'h0111);
    end
    @(negedge clk);
    wr_en2 = 1'b0;
    save_req2 = 1'b1;
    @(posedge clk); #1;
    check("w2 E0 state", 32'(state_o2), 32'd1);
    lat = 0;
    while (!save_ack2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w2 save latency", 32'(lat), 32'd1);
    check("w2 saved state", 32'(state_o2), 32'd2);

    @(negedge clk);
    pwr_on2 = 1'b0; save_req2 = 1'b0;
    @(posedge clk); #1;
    check("w2 off state", 32'(state_o2), 32'd3);
    check("w2 off err", 32'(err2), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr2 = 3'(i);
      #1;
      check($sformatf("w2 corrupt[%0d]", i), 32'(rd_data2), 32'hDEAD);
    end

    @(negedge clk);
    pwr_on2 = 1'b1; restore_req2 = 1'b1;
    @(posedge clk); #1;
    check("w2 R0 state", 32'(state_o2), 32'd4);
    lat = 0;
    while (!restore_ack2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w2 restore latency", 32'(lat), 32'd5);
    check("w2 restored state", 32'(state_o2), 32'd5);
    check("w2 restored err", 32'(err2), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr2 = 3'(i);
      #1;
      check($sformatf("w2 live[%0d]", i), 32'(rd_data2), 32'(16'h1000 + i * 16'h0111));
    end

    @(negedge clk);
    restore_req2 = 1'b0;
    @(posedge clk); #1;
    check("w2 back state", 32'(state_o2), 32'd0);
    check("w2 back restore_ack", 32'(restore_ack2), 32'd0);
    check("w2 back save_ack", 32'(save_ack2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
